wb_unit: RTL and testbench
==========================

// Module: wb_unit
// PURPOSE
//  Writeback stage of the pipelined core. Holds the M->W pipeline register and selects the result.
//  Aligns and extends load data. Drives the register-file write port (RegWriteW/ResultW/RdW) consumed by decode.
//  Loads are returned by a variable-latency data memory, so a 2-state FSM stalls the pipeline until load data arrives.
// PARAMETERS
//  XLEN  32  datapath width; only 32 is supported
// PORTS
//  clk           in   1   core clock, rising edge
//  reset         in   1   asynchronous, active-high reset
//  validM        in   1   M-stage slot holds a real instruction
//  RegWriteM     in   1   instruction writes rd
//  ResultSrcM    in   2   00 ALU, 01 load, 10 PC+4, 11 reserved (treated as ALU)
//  Funct3M       in   3   load size/sign code
//  RdM           in   5   destination register
//  ALUResultM    in   32  ALU result / load address
//  PCplus4M      in   32  link value
//  ReadDataM     in   32  data-memory read word (aligned word)
//  ReadValidM    in   1   ReadDataM valid this cycle
//  stallW        out  1   hold F/D/E/M stages (a load is waiting in W)
//  RegWriteW     out  1   register-file write enable
//  RdW           out  5   register-file write address
//  ResultW       out  32  register-file write data
//  instretW      out  64  retired-instruction count (only with WB_INSTRET_EN)
// BEHAVIOUR
//  Reset: state=IDLE; all W registers 0; stallW=0, RegWriteW=0, RdW=0, ResultW=0, instretW=0.
//  Reset asserted mid-WAIT: the pending load is abandoned and never written back.
//  W registers: wb_valid, wb_regwrite, wb_src, wb_f3, wb_rd, wb_alu, wb_pc4, wb_rdata.
//  IDLE, each edge:
//   - All W registers load from the M inputs.
//   - If validM & ResultSrcM==01: if ReadValidM, capture ReadDataM into wb_rdata and stay IDLE;
//     otherwise go to WAIT.
//  WAIT:
//   - W registers hold; stallW=1.
//   - On an edge with ReadValidM=1: wb_rdata<=ReadDataM and state<=IDLE.
//   - M inputs are ignored while in WAIT; upstream holds them stable because stallW=1.
//  stallW = (state==WAIT). It is a pure decode of the state register, with no path from the inputs.
//  Retire: the W slot retires in any cycle where wb_valid & state==IDLE.
//  RegWriteW = retire & wb_regwrite & (wb_rd!=0) & ~illegal_load. It is never 1 in WAIT.
//  RdW = wb_rd. ResultW is driven from the W registers regardless of state.
//  Result select: 00/11 -> wb_alu; 10 -> wb_pc4; 01 -> load-aligned value.
//  Load align (off = wb_alu[1:0]):
//   - LB 000: sign-extend byte[off].  LBU 100: zero-extend byte[off].
//   - LH 001: sign-extend half[off[1]]; off[0] ignored.  LHU 101: zero-extend half[off[1]].
//   - LW 010: whole word; off ignored.
//   - 011/110/111: illegal_load=1, result 0, no write.
//  Latency: a non-load, or a load with data in the same cycle, gives RegWriteW one cycle after the M inputs.
//   A load with data arriving k cycles later writes at cycle k+1 and stalls for k cycles.
//  ReadValidM while not IDLE-capturing-a-load and not in WAIT: ignored.
//  Regfile write-before-read (same-cycle forwarding to decode) is the regfile's responsibility, not this block's.
// CONFIGURATION
//  WB_INSTRET_EN defined:
//   - 64-bit instretW increments by 1 on every retire cycle, including rd=x0 and no-write instructions.
//   - Wraps at 2^64-1 -> 0.
//  WB_INSTRET_EN undefined: instretW port and counter are absent.
// STRUCTURE
//  Package wb_pkg holds:
//   - RESULT_ALU/RESULT_LOAD/RESULT_PC4 (2-bit)
//   - F3_LB/LH/LW/LBU/LHU (3-bit)
//   - wb_state_t {WB_IDLE, WB_WAIT}
//  Sub-module load_align (combinational): inputs rdata, off, f3; outputs value, illegal.
//  The FSM, W registers and optional counter live in wb_unit.
// TESTING
//  1. ALU op: validM=1, RegWriteM=1, Src=00, Rd=5, ALU=0x1234 -> next cycle RegWriteW=1, RdW=5, ResultW=0x1234, stallW=0.
//  2. LB: ALU=0x1003, ReadValidM=1 with ReadData=0x80FF_FF00 -> ResultW=0xFFFF_FF80. LBU at the same address -> 0x80.
//  3. Late load: LW with ReadValidM=0 for 3 cycles, then data 0xDEADBEEF
//     -> stallW=1 for exactly 3 cycles, RegWriteW=0 during them, then RegWriteW=1 with ResultW=0xDEADBEEF.
//  4. Rd=0 or funct3=011 -> RegWriteW stays 0. JAL Src=10, PC+4=0x44 -> ResultW=0x44.
//  5. Reset pulse during WAIT -> state IDLE, stallW=0, no write ever issued for that load.
//  6. (WB_INSTRET_EN) 10 back-to-back retires plus one 2-cycle load stall -> instretW=11, with no increment during the stall.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared constants and types for the writeback stage: result-source codes,
// load funct3 codes and the load-wait FSM state type.
package wb_pkg;

    localparam logic [1:0] RESULT_ALU  = 2'b00;
    localparam logic [1:0] RESULT_LOAD = 2'b01;
    localparam logic [1:0] RESULT_PC4  = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        WB_IDLE = 1'b0,
        WB_WAIT = 1'b1
    } wb_state_t;

    function automatic logic isLoad(input logic valid, input logic [1:0] src);
        return valid && (src == RESULT_LOAD);
    endfunction

endpackage

// File: rtl/wb_unit_if.sv
// M->W pipeline inputs and register-file write-port outputs of the writeback stage.
// The slave modport is the writeback unit; master is whoever drives the M stage.
interface wb_unit_if #(parameter int XLEN = 32) ();

    logic            validM;
    logic            RegWriteM;
    logic [1:0]      ResultSrcM;
    logic [2:0]      Funct3M;
    logic [4:0]      RdM;
    logic [XLEN-1:0] ALUResultM;
    logic [XLEN-1:0] PCplus4M;
    logic [XLEN-1:0] ReadDataM;
    logic            ReadValidM;

    logic            stallW;
    logic            RegWriteW;
    logic [4:0]      RdW;
    logic [XLEN-1:0] ResultW;

    modport slave (
        input  validM, RegWriteM, ResultSrcM, Funct3M, RdM,
               ALUResultM, PCplus4M, ReadDataM, ReadValidM,
        output stallW, RegWriteW, RdW, ResultW
    );

    modport master (
        output validM, RegWriteM, ResultSrcM, Funct3M, RdM,
               ALUResultM, PCplus4M, ReadDataM, ReadValidM,
        input  stallW, RegWriteW, RdW, ResultW
    );

endinterface

// File: rtl/wb_unit_load_align.sv
// Combinational load alignment: picks the byte/half/word addressed by off out of
// the aligned memory word and sign- or zero-extends it; flags unsupported funct3.
module load_align
    import wb_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  f3,
    output logic [31:0] value,
    output logic        illegal
);

    logic [7:0]  byteLane [4];
    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign byteLane[gi] = rdata[8*gi +: 8];
        end
    endgenerate

    assign byteSel = byteLane[off];
    // Halfword loads ignore off[0]; misaligned halves are not split across words.
    assign halfSel = off[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        value   = '0;
        illegal = 1'b0;
        case (f3)
            F3_LB:   value = {{24{byteSel[7]}}, byteSel};
            F3_LBU:  value = {24'h0, byteSel};
            F3_LH:   value = {{16{halfSel[15]}}, halfSel};
            F3_LHU:  value = {16'h0, halfSel};
            F3_LW:   value = rdata;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_unit.sv
// Writeback stage: M->W pipeline register, load-wait FSM, result select and
// register-file write port. Define WB_INSTRET_EN to add the 64-bit retire counter.
module wb_unit
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic        clk,
    input  logic        reset,
    wb_unit_if.slave    bus
`ifdef WB_INSTRET_EN
    ,
    output logic [63:0] instretW
`endif
);

    wb_state_t       stateReg;
    wb_state_t       stateNext;

    logic            wbValidReg;
    logic            wbRegwriteReg;
    logic [1:0]      wbSrcReg;
    logic [2:0]      wbF3Reg;
    logic [4:0]      wbRdReg;
    logic [XLEN-1:0] wbAluReg;
    logic [XLEN-1:0] wbPc4Reg;
    logic [XLEN-1:0] wbRdataReg;

    logic [XLEN-1:0] loadValue;
    logic            loadIllegal;
    logic            illegalLoad;
    logic            retire;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateReg <= WB_IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            WB_IDLE: begin
                if (isLoad(bus.validM, bus.ResultSrcM) && !bus.ReadValidM) begin
                    stateNext = WB_WAIT;
                end
            end
            WB_WAIT: begin
                if (bus.ReadValidM) begin
                    stateNext = WB_IDLE;
                end
            end
            default: stateNext = WB_IDLE;
        endcase
    end

    // In WAIT the slot is frozen; only the read data is still allowed to land.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wbValidReg    <= 1'b0;
            wbRegwriteReg <= 1'b0;
            wbSrcReg      <= '0;
            wbF3Reg       <= '0;
            wbRdReg       <= '0;
            wbAluReg      <= '0;
            wbPc4Reg      <= '0;
            wbRdataReg    <= '0;
        end else if (stateReg == WB_IDLE) begin
            wbValidReg    <= bus.validM;
            wbRegwriteReg <= bus.RegWriteM;
            wbSrcReg      <= bus.ResultSrcM;
            wbF3Reg       <= bus.Funct3M;
            wbRdReg       <= bus.RdM;
            wbAluReg      <= bus.ALUResultM;
            wbPc4Reg      <= bus.PCplus4M;
            wbRdataReg    <= bus.ReadDataM;
        end else if (bus.ReadValidM) begin
            wbRdataReg    <= bus.ReadDataM;
        end
    end

    load_align u_align (
        .rdata   (wbRdataReg),
        .off     (wbAluReg[1:0]),
        .f3      (wbF3Reg),
        .value   (loadValue),
        .illegal (loadIllegal)
    );

    // funct3 only means a load size when the slot actually selects load data.
    assign illegalLoad = (wbSrcReg == RESULT_LOAD) && loadIllegal;
    assign retire      = wbValidReg && (stateReg == WB_IDLE);

    assign bus.stallW    = (stateReg == WB_WAIT);
    assign bus.RegWriteW = retire && wbRegwriteReg && (wbRdReg != 5'd0) && !illegalLoad;
    assign bus.RdW       = wbRdReg;

    always_comb begin
        bus.ResultW = wbAluReg;
        case (wbSrcReg)
            RESULT_PC4:  bus.ResultW = wbPc4Reg;
            RESULT_LOAD: bus.ResultW = loadValue;
            default:     bus.ResultW = wbAluReg;
        endcase
    end

`ifdef WB_INSTRET_EN
    logic [63:0] instretReg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instretReg <= '0;
        end else if (retire) begin
            instretReg <= instretReg + 64'd1;
        end
    end

    assign instretW = instretReg;
`endif

endmodule

// File: tb/tb_wb_unit.sv
// Directed bench for wb_unit: stimulus pushes expected register-file writes into
// a queue, a negedge monitor pops and compares every RegWriteW pulse.
module tb_wb_unit;
    import wb_pkg::*;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] result;
    } exp_t;

    logic clk;
    logic reset;

    wb_unit_if #(.XLEN(32)) bus ();

`ifdef WB_INSTRET_EN
    logic [63:0] instretW;
`endif

    wb_unit #(.XLEN(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus)
`ifdef WB_INSTRET_EN
        ,
        .instretW (instretW)
`endif
    );

    exp_t  expQ[$];
    string nameQ[$];
    int    nCompared;
    int    nMismatch;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        nCompared++;
        if (act !== req) begin
            nMismatch++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every write pulse must match the oldest outstanding expectation.
    initial begin
        exp_t  e;
        string n;
        forever begin
            @(negedge clk);
            if (!reset && bus.RegWriteW === 1'b1) begin
                check("write_while_stalled", {63'd0, bus.stallW}, 64'd0);
                if (expQ.size() == 0) begin
                    nCompared++;
                    nMismatch++;
                    $display("FAIL unexpected_write: rd=%0d result=0x%08h, required no write",
                             bus.RdW, bus.ResultW);
                end else begin
                    e = expQ.pop_front();
                    n = nameQ.pop_front();
                    $display("write %s: rd=%0d result=0x%08h (required rd=%0d result=0x%08h)",
                             n, bus.RdW, bus.ResultW, e.rd, e.result);
                    check({n, "_rd"}, {59'd0, bus.RdW}, {59'd0, e.rd});
                    check({n, "_result"}, {32'd0, bus.ResultW}, {32'd0, e.result});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic v, input logic rw, input logic [1:0] src,
                         input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] pc4,
                         input logic [31:0] rdata, input logic rv);
        @(posedge clk);
        #1;
        bus.validM     = v;
        bus.RegWriteM  = rw;
        bus.ResultSrcM = src;
        bus.Funct3M    = f3;
        bus.RdM        = rd;
        bus.ALUResultM = alu;
        bus.PCplus4M   = pc4;
        bus.ReadDataM  = rdata;
        bus.ReadValidM = rv;
    endtask

    task automatic nop();
        drive(1'b0, 1'b0, RESULT_ALU, 3'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0);
    endtask

    // Single-cycle instruction; the memory (if a load) answers in the same cycle.
    task automatic op(input string name, input logic v, input logic rw, input logic [1:0] src,
                      input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] alu,
                      input logic [31:0] pc4, input logic [31:0] rdata,
                      input logic expWr, input logic [31:0] expRes);
        exp_t e;
        drive(v, rw, src, f3, rd, alu, pc4, rdata, 1'b1);
        $display("issue %s: rd=%0d alu=0x%08h rdata=0x%08h expect_write=%0d",
                 name, rd, alu, rdata, expWr);
        if (expWr) begin
            e.rd     = rd;
            e.result = expRes;
            expQ.push_back(e);
            nameQ.push_back(name);
        end
        @(negedge clk);
        check({name, "_stall"}, {63'd0, bus.stallW}, 64'd0);
    endtask

    task automatic expectLate(input string name, input logic [4:0] rd, input logic [31:0] res);
        exp_t e;
        e.rd     = rd;
        e.result = res;
        expQ.push_back(e);
        nameQ.push_back(name);
    endtask

    initial begin
        nCompared      = 0;
        nMismatch      = 0;
        reset          = 1'b0;
        bus.validM     = 1'b0;
        bus.RegWriteM  = 1'b0;
        bus.ResultSrcM = 2'b00;
        bus.Funct3M    = 3'd0;
        bus.RdM        = 5'd0;
        bus.ALUResultM = 32'h0;
        bus.PCplus4M   = 32'h0;
        bus.ReadDataM  = 32'h0;
        bus.ReadValidM = 1'b0;

        // Reset takes effect before any clock edge.
        #1 reset = 1'b1;
        #1;
        check("reset_stallW",    {63'd0, bus.stallW},    64'd0);
        check("reset_RegWriteW", {63'd0, bus.RegWriteW}, 64'd0);
        check("reset_RdW",       {59'd0, bus.RdW},       64'd0);
        check("reset_ResultW",   {32'd0, bus.ResultW},   64'd0);
`ifdef WB_INSTRET_EN
        check("reset_instretW", instretW, 64'd0);
`endif
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;

        //   name          v     rw    src          f3      rd     alu           pc4           rdata         wr    result
        op("alu",         1'b1, 1'b1, RESULT_ALU,  3'd0,   5'd5,  32'h0000_1234, 32'h0,       32'h0,        1'b1, 32'h0000_1234);
        op("lb_off3",     1'b1, 1'b1, RESULT_LOAD, F3_LB,  5'd6,  32'h0000_1003, 32'h0,       32'h80FF_FF00, 1'b1, 32'hFFFF_FF80);
        op("lbu_off3",    1'b1, 1'b1, RESULT_LOAD, F3_LBU, 5'd7,  32'h0000_1003, 32'h0,       32'h80FF_FF00, 1'b1, 32'h0000_0080);
        op("lb_off1",     1'b1, 1'b1, RESULT_LOAD, F3_LB,  5'd11, 32'h0000_1001, 32'h0,       32'h80FF_FF00, 1'b1, 32'hFFFF_FFFF);
        op("lbu_off0",    1'b1, 1'b1, RESULT_LOAD, F3_LBU, 5'd12, 32'h0000_1000, 32'h0,       32'h80FF_FF00, 1'b1, 32'h0000_0000);
        op("lh_off2",     1'b1, 1'b1, RESULT_LOAD, F3_LH,  5'd8,  32'h0000_2002, 32'h0,       32'h80FF_FF00, 1'b1, 32'hFFFF_80FF);
        op("lhu_off0",    1'b1, 1'b1, RESULT_LOAD, F3_LHU, 5'd9,  32'h0000_2000, 32'h0,       32'h80FF_FF00, 1'b1, 32'h0000_FF00);
        op("lh_off1",     1'b1, 1'b1, RESULT_LOAD, F3_LH,  5'd10, 32'h0000_2001, 32'h0,       32'h80FF_FF00, 1'b1, 32'hFFFF_FF00);
        op("lhu_off3",    1'b1, 1'b1, RESULT_LOAD, F3_LHU, 5'd13, 32'h0000_2003, 32'h0,       32'h7F00_1234, 1'b1, 32'h0000_7F00);
        op("lw_off3",     1'b1, 1'b1, RESULT_LOAD, F3_LW,  5'd14, 32'h0000_3003, 32'h0,       32'h1234_5678, 1'b1, 32'h1234_5678);
        op("load_f3_011", 1'b1, 1'b1, RESULT_LOAD, 3'b011, 5'd15, 32'h0000_3000, 32'h0,       32'h1234_5678, 1'b0, 32'h0);
        op("load_f3_110", 1'b1, 1'b1, RESULT_LOAD, 3'b110, 5'd16, 32'h0000_3000, 32'h0,       32'h1234_5678, 1'b0, 32'h0);
        op("load_f3_111", 1'b1, 1'b1, RESULT_LOAD, 3'b111, 5'd17, 32'h0000_3000, 32'h0,       32'h1234_5678, 1'b0, 32'h0);
        op("alu_rd0",     1'b1, 1'b1, RESULT_ALU,  3'd0,   5'd0,  32'h0000_7777, 32'h0,       32'h0,        1'b0, 32'h0);
        op("jal",         1'b1, 1'b1, RESULT_PC4,  3'd0,   5'd1,  32'h0000_9999, 32'h0000_0044, 32'h0,      1'b1, 32'h0000_0044);
        op("src_11",      1'b1, 1'b1, 2'b11,       3'd0,   5'd18, 32'h0000_CAFE, 32'h0000_0044, 32'h0,      1'b1, 32'h0000_CAFE);
        op("alu_f3_011",  1'b1, 1'b1, RESULT_ALU,  3'b011, 5'd19, 32'h0000_0001, 32'h0,       32'h0,        1'b1, 32'h0000_0001);
        op("bubble",      1'b0, 1'b1, RESULT_ALU,  3'd0,   5'd20, 32'h0000_5555, 32'h0,       32'h0,        1'b0, 32'h0);
        op("no_regwrite", 1'b1, 1'b0, RESULT_ALU,  3'd0,   5'd21, 32'h0000_6666, 32'h0,       32'h0,        1'b0, 32'h0);

        // Late LW: memory silent for 3 cycles, data on the 4th; M inputs changed in WAIT must be ignored.
        expectLate("late_lw", 5'd22, 32'hDEAD_BEEF);
        drive(1'b1, 1'b1, RESULT_LOAD, F3_LW, 5'd22, 32'h0000_4000, 32'h0, 32'h0, 1'b0);
        $display("issue late_lw: rd=22 data after 3 cycles");
        @(negedge clk);
        check("late_c0_stall", {63'd0, bus.stallW}, 64'd0);
        drive(1'b1, 1'b1, RESULT_ALU, 3'd0, 5'd31, 32'h1111_1111, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        check("late_c1_stall", {63'd0, bus.stallW}, 64'd1);
        drive(1'b1, 1'b1, RESULT_ALU, 3'd0, 5'd31, 32'h2222_2222, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        check("late_c2_stall", {63'd0, bus.stallW}, 64'd1);
        drive(1'b1, 1'b1, RESULT_ALU, 3'd0, 5'd31, 32'h3333_3333, 32'h0, 32'hDEAD_BEEF, 1'b1);
        @(negedge clk);
        check("late_c3_stall", {63'd0, bus.stallW}, 64'd1);
        nop();
        @(negedge clk);
        check("late_c4_stall", {63'd0, bus.stallW}, 64'd0);
        check("late_c4_regwrite", {63'd0, bus.RegWriteW}, 64'd1);

        // Reset mid-WAIT abandons the pending load.
        drive(1'b1, 1'b1, RESULT_LOAD, F3_LW, 5'd23, 32'h0000_5000, 32'h0, 32'h0, 1'b0);
        $display("issue abandoned_lw: rd=23, reset during wait");
        @(negedge clk);
        drive(1'b1, 1'b1, RESULT_LOAD, F3_LW, 5'd23, 32'h0000_5000, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        check("rstwait_pre_stall", {63'd0, bus.stallW}, 64'd1);
        #2 reset = 1'b1;
        #1;
        check("rstwait_stallW",    {63'd0, bus.stallW},    64'd0);
        check("rstwait_RegWriteW", {63'd0, bus.RegWriteW}, 64'd0);
        @(posedge clk);
        #1;
        reset          = 1'b0;
        bus.validM     = 1'b0;
        bus.ReadDataM  = 32'h5555_AAAA;
        bus.ReadValidM = 1'b1;
        @(negedge clk);
        check("rstwait_post_stall", {63'd0, bus.stallW}, 64'd0);
        nop();
        nop();

`ifdef WB_INSTRET_EN
        // Fresh count: 10 back-to-back retires (incl. rd=x0 and no-write) and one 2-cycle load stall.
        @(posedge clk);
        #1 reset = 1'b1;
        #1 reset = 1'b0;
        check("instret_cleared", instretW, 64'd0);
        for (int i = 0; i < 10; i++) begin
            op($sformatf("ret%0d", i), 1'b1, (i != 5), RESULT_ALU, 3'd0, 5'(i),
               32'h100 + 32'(i), 32'h0, 32'h0, (i != 0) && (i != 5), 32'h100 + 32'(i));
        end
        expectLate("ret_lw", 5'd24, 32'hA5A5_0001);
        drive(1'b1, 1'b1, RESULT_LOAD, F3_LW, 5'd24, 32'h0000_6000, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b1, RESULT_LOAD, F3_LW, 5'd24, 32'h0000_6000, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        check("instret_stall1", instretW, 64'd10);
        check("instret_stall1_st", {63'd0, bus.stallW}, 64'd1);
        drive(1'b1, 1'b1, RESULT_LOAD, F3_LW, 5'd24, 32'h0000_6000, 32'h0, 32'hA5A5_0001, 1'b1);
        @(negedge clk);
        check("instret_stall2", instretW, 64'd10);
        nop();
        @(negedge clk);
        check("instret_load_retiring", instretW, 64'd10);
        nop();
        @(negedge clk);
        check("instret_final", instretW, 64'd11);
`endif

        nop();
        nop();
        @(negedge clk);
        check("queue_drained", 64'(expQ.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
